// File: rtl/system_bus_pkg.sv
// Shared types and constants for the system-bus slave legs.
package system_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RWAIT,
        RDATA
    } bus_slave_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_slave_port_if.sv
// Serial valid/ready handshake between the arbiter (master side) and one slave leg.
interface bus_slave_port_if;

    logic mode;
    logic wr_bus;
    logic master_valid;
    logic slave_ready;
    logic rd_bus;
    logic slave_valid;
    logic master_ready;
    logic split;

    modport slave (
        input  mode,
        input  wr_bus,
        input  master_valid,
        input  master_ready,
        output slave_ready,
        output rd_bus,
        output slave_valid,
        output split
    );

    modport master (
        output mode,
        output wr_bus,
        output master_valid,
        output master_ready,
        input  slave_ready,
        input  rd_bus,
        input  slave_valid,
        input  split
    );

endinterface

// File: rtl/slave_mem.sv
// Single-port synchronous RAM: write on enable, registered 1-cycle read that
// holds its value until the next read.
module slave_mem #(
    parameter int DEPTH      = 4096,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array write and read-data register; contents survive reset by design.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_port.sv
// Bit-serial bus responder fronting a local RAM.
//
// state | meaning
// IDLE  | waiting for the first address bit (latches mode)
// ADDR  | shifting in the remaining address bits
// WDATA | shifting in write data
// WRITE | one-cycle memory write (dropped when out of range)
// RWAIT | read issued on first cycle, then READ_LATENCY wait cycles
// RDATA | shifting read data out under master_ready
module bus_slave_port
    import system_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 4,
    parameter int SPLIT_EN     = 0,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    bus_slave_port_if.slave bus
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]     TO_LOAD   = TO_W'(TIMEOUT);
    localparam logic [7:0]          RL_LOAD   = 8'(READ_LATENCY);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    bus_slave_state_t        state_q;
    logic                    mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [7:0]              wait_cnt_q;
    logic                    rd_issue_q;
    logic [TO_W-1:0]         to_cnt_q;

    logic                    xfer_in;
    logic                    addr_ok;
    logic                    timeout_hit;
    logic                    mem_we;
    logic                    mem_re;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign bus.slave_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
    assign bus.slave_valid = (state_q == RDATA);
    assign bus.rd_bus      = (state_q == RDATA) && data_q[DATA_WIDTH-1];
    // The read-issue cycle is excluded so split covers only the wait cycles.
    assign bus.split       = (SPLIT_EN != 0) && (state_q == RWAIT) && !rd_issue_q;

    assign xfer_in     = bus.master_valid && bus.slave_ready;
    assign addr_ok     = {1'b0, addr_q} < DEPTH_LIM;
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(1));
    assign mem_we      = (state_q == WRITE) && addr_ok;
    assign mem_re      = (state_q == RWAIT) && rd_issue_q;

    // Frame sequencer: shifting, read wait down-counter and mid-frame timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_READ;
            addr_q     <= '0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rd_issue_q <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_in) begin
                        mode_q    <= bus.mode;
                        addr_q    <= {{(ADDR_WIDTH-1){1'b0}}, bus.wr_bus};
                        bit_cnt_q <= CNT_W'(1);
                        to_cnt_q  <= TO_LOAD;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (xfer_in) begin
                        addr_q   <= {addr_q[ADDR_WIDTH-2:0], bus.wr_bus};
                        to_cnt_q <= TO_LOAD;
                        if (bit_cnt_q == ADDR_LAST) begin
                            bit_cnt_q <= '0;
                            if (mode_q == MODE_WRITE) begin
                                state_q <= WDATA;
                            end else begin
                                state_q    <= RWAIT;
                                rd_issue_q <= 1'b1;
                                wait_cnt_q <= RL_LOAD;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        to_cnt_q <= to_cnt_q - 1'b1;
                    end
                end
                WDATA: begin
                    if (xfer_in) begin
                        data_q   <= {data_q[DATA_WIDTH-2:0], bus.wr_bus};
                        to_cnt_q <= TO_LOAD;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= WRITE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        to_cnt_q <= to_cnt_q - 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                RWAIT: begin
                    if (rd_issue_q) begin
                        rd_issue_q <= 1'b0;
                    end else if (wait_cnt_q == 8'd1) begin
                        data_q  <= addr_ok ? mem_rdata : '0;
                        state_q <= RDATA;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                RDATA: begin
                    if (bus.master_ready) begin
                        data_q <= {data_q[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    slave_mem #(
        .DEPTH      (MEM_DEPTH),
        .WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH (IDX_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_q[IDX_W-1:0]),
        .wdata_i (data_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_bus_slave_port.sv
// Self-checking bench for bus_slave_port: directed frames plus a random
// read/write mix against a memory-array model with spec-derived timing.
module tb_bus_slave_port;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;
    localparam int RL    = 4;
    localparam int SPLIT = 1;
    localparam int TO    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_slave_port_if bus();

    bus_slave_port #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (RL),
        .SPLIT_EN     (SPLIT),
        .TIMEOUT      (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic chk_en    = 1'b0;
    logic exp_ready = 1'b1;
    logic exp_valid = 1'b0;
    logic exp_split = 1'b0;
    logic exp_rd    = 1'b0;

    logic [7:0] model_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle output compare against the expected handshake picture.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("slave_ready", bus.slave_ready, exp_ready);
            chk("slave_valid", bus.slave_valid, exp_valid);
            chk("split", bus.split, exp_split);
            if (exp_valid) chk("rd_bus", bus.rd_bus, exp_rd);
        end
    end

    function automatic int rgap(input int mx);
        if (mx == 0) return 0;
        return ($urandom % 2) ? 0 : int'($urandom_range(mx, 1));
    endfunction

    task automatic idle_cycles(input int n);
        bus.master_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic md, input logic b, input int gap);
        idle_cycles(gap);
        bus.mode         = md;
        bus.wr_bus       = b;
        bus.master_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.master_valid = 1'b0;
    endtask

    // Sends a write frame; nd < DW abandons it after nd data bits.
    task automatic write_frame(input logic [11:0] a, input logic [7:0] d, input int gmax,
                               input int nd, input int stall_len);
        for (int i = AW - 1; i >= 0; i--) drive_bit(1'b1, a[i], rgap(gmax));
        for (int j = 0; j < DW; j++) begin
            if (j == 3 && stall_len > 0) idle_cycles(stall_len);
            if (j >= nd) break;
            drive_bit(1'b1, d[DW-1-j], rgap(gmax));
        end
        if (nd >= DW) begin
            exp_ready = 1'b0;
            @(posedge clk);
            #1;
            exp_ready = 1'b1;
            if (a < DEPTH) model_mem[int'(a)] = d;
        end
    endtask

    task automatic read_frame(input logic [11:0] a, input int gmax, input int stall_first,
                              input int abort_after, output logic [7:0] word,
                              output int lat, output int nsplit);
        logic [7:0] exp_w;
        exp_w = 8'h00;
        if (a < DEPTH) exp_w = model_mem[int'(a)];
        word   = 8'h00;
        lat    = 0;
        nsplit = 0;
        for (int i = AW - 1; i >= 0; i--) drive_bit(1'b0, a[i], rgap(gmax));
        exp_ready = 1'b0;
        exp_split = 1'b0;
        for (int k = 1; k <= RL + 1; k++) begin
            @(negedge clk);
            if (!bus.slave_valid) lat++;
            if (bus.split) nsplit++;
            @(posedge clk);
            #1;
            if (k <= RL) begin
                exp_split = (SPLIT != 0);
            end else begin
                exp_split = 1'b0;
                exp_valid = 1'b1;
            end
        end
        for (int i = DW - 1; i >= 0; i--) begin
            int ns;
            exp_rd = exp_w[i];
            ns = (i == DW - 1) ? stall_first : rgap(3);
            bus.master_ready = 1'b0;
            repeat (ns) begin
                @(posedge clk);
                #1;
            end
            bus.master_ready = 1'b1;
            @(negedge clk);
            word[i] = bus.rd_bus;
            @(posedge clk);
            #1;
            bus.master_ready = 1'b0;
            if (abort_after == DW - i) begin
                rst       = 1'b1;
                exp_valid = 1'b0;
                exp_ready = 1'b1;
                exp_split = 1'b0;
                #1;
                chk("abort_valid", bus.slave_valid, 1'b0);
                chk("abort_ready", bus.slave_ready, 1'b1);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        chk("rdata", word, exp_w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  w;
        int          lat;
        int          nsp;
        logic [11:0] pool [8];

        pool = '{12'h003, 12'h010, 12'h020, 12'h7FF, 12'h800, 12'h000, 12'h555, 12'hFFF};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        bus.mode         = 1'b0;
        bus.wr_bus       = 1'b0;
        bus.master_valid = 1'b0;
        bus.master_ready = 1'b0;
        rst              = 1'b1;

        #2;
        chk("rst_ready", bus.slave_ready, 1'b1);
        chk("rst_valid", bus.slave_valid, 1'b0);
        chk("rst_rd_bus", bus.rd_bus, 1'b0);
        chk("rst_split", bus.split, 1'b0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Out-of-range write must not alias onto address 0.
        write_frame(12'h800, 8'h3C, 0, 8, 0);
        read_frame(12'h000, 0, 0, 0, w, lat, nsp);
        chk("alias_rd", w, 8'h00);

        // Basic write then read with latency and split length.
        write_frame(12'h003, 8'hA5, 0, 8, 0);
        read_frame(12'h003, 0, 0, 0, w, lat, nsp);
        chk("a5_rd", w, 8'hA5);
        chk("a5_latency", lat, 5);
        chk("a5_split_cycles", nsp, 4);

        read_frame(12'hFFF, 0, 0, 0, w, lat, nsp);
        chk("fff_rd", w, 8'h00);

        // Long master_ready stall holds the first bit.
        write_frame(12'h010, 8'h5A, 1, 8, 0);
        read_frame(12'h010, 0, 20, 0, w, lat, nsp);
        chk("stall_rd", w, 8'h5A);

        // Timeout abandons a partial write; new frame accepted afterwards.
        write_frame(12'h003, 8'hFF, 0, 3, 64);
        write_frame(12'h020, 8'h77, 0, 8, 0);
        read_frame(12'h003, 0, 0, 0, w, lat, nsp);
        chk("timeout_nowrite", w, 8'hA5);
        read_frame(12'h020, 0, 0, 0, w, lat, nsp);
        chk("after_timeout_rd", w, 8'h77);

        // One idle cycle short of the timeout: frame still completes.
        write_frame(12'h030, 8'h81, 0, 8, 63);
        read_frame(12'h030, 0, 0, 0, w, lat, nsp);
        chk("near_timeout_rd", w, 8'h81);

        // Reset mid-read, then a clean read of the same word.
        read_frame(12'h010, 0, 0, 4, w, lat, nsp);
        read_frame(12'h010, 0, 0, 0, w, lat, nsp);
        chk("after_abort_rd", w, 8'h5A);

        // Random back-to-back mix.
        for (int n = 0; n < 60; n++) begin
            logic [11:0] a;
            logic [7:0]  d;
            a = (($urandom % 4) == 0) ? 12'($urandom_range(4095, 0)) : pool[$urandom % 8];
            d = 8'($urandom);
            if ($urandom % 2) begin
                write_frame(a, d, 3, 8, 0);
            end else begin
                read_frame(a, 3, int'($urandom_range(4, 0)), 0, w, lat, nsp);
                chk("rand_latency", lat, RL + 1);
                chk("rand_split_cycles", nsp, RL);
            end
            if (($urandom % 3) == 0) idle_cycles(int'($urandom_range(3, 1)));
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
